param_loader: RTL and testbench

Write-side counterpart of the inference engine's parameter memory. Accepts a stream of 16-bit words over a valid/ready handshake after a `start` pulse, and emits registered write strobes into the weight and bias storage. Addresses use the same packing the read side uses: weights `{n[2:0], i[1:0], k[1:0]}` and biases `{n[2:0], k[1:0]}`. The block sits between the host/config interface and the parameter memory, and runs once before each inference session.

---
 rtl/param_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_param_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_loader.sv
// Streams host words into weight/bias write strobes; optional trailing checksum under PARAM_LOADER_CHECKSUM_EN.
// Write latency 1 cycle; in_ready is registered from state only, stalls on in_valid=0 hold all counters.
module param_loader #(
  parameter int N_NEURONS = 8,
  parameter int N_INPUTS  = 4,
  parameter int K_WORDS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        w_we,
  output logic [6:0]  w_addr,
  output logic        b_we,
  output logic [4:0]  b_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_B = 3'd2,
`ifdef PARAM_LOADER_CHECKSUM_EN
    S_CHK    = 3'd3,
`endif
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] N_LAST = 3'(N_NEURONS - 1);
  localparam logic [1:0] I_LAST = 2'(N_INPUTS - 1);
  localparam logic [1:0] K_LAST = 2'(K_WORDS - 1);

  state_t      state_q, state_d;
  logic [2:0]  n_q, n_d;
  logic [1:0]  i_q, i_d;
  logic [1:0]  k_q, k_d;
  logic        in_ready_q, in_ready_d;
  logic        w_we_q, w_we_d;
  logic        b_we_q, b_we_d;
  logic [6:0]  w_addr_q, w_addr_d;
  logic [4:0]  b_addr_q, b_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic        err_q, err_d;
`endif

  logic beat;
  logic last_n, last_i, last_k;

  always_comb begin
    beat   = in_valid & in_ready_q;
    last_n = (n_q == N_LAST);
    last_i = (i_q == I_LAST);
    last_k = (k_q == K_LAST);

    state_d   = state_q;
    n_d       = n_q;
    i_d       = i_q;
    k_d       = k_q;
    w_we_d    = 1'b0;
    b_we_d    = 1'b0;
    w_addr_d  = w_addr_q;
    b_addr_d  = b_addr_q;
    wr_data_d = wr_data_q;
`ifdef PARAM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = err_q;
`endif

    // abort wins over start and over a beat accepted in the same cycle
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD_W;
            n_d     = 3'd0;
            i_d     = 2'd0;
            k_d     = 2'd0;
`ifdef PARAM_LOADER_CHECKSUM_EN
            sum_d   = 16'd0;
            err_d   = 1'b0;
`endif
          end
        end
        S_LOAD_W: begin
          if (beat) begin
            w_we_d    = 1'b1;
            w_addr_d  = {n_q, i_q, k_q};
            wr_data_d = in_data;
`ifdef PARAM_LOADER_CHECKSUM_EN
            sum_d     = sum_q + in_data;
`endif
            if (!last_k) begin
              k_d = k_q + 2'd1;
            end else begin
              k_d = 2'd0;
              if (!last_i) begin
                i_d = i_q + 2'd1;
              end else begin
                i_d = 2'd0;
                if (!last_n) begin
                  n_d = n_q + 3'd1;
                end else begin
                  n_d     = 3'd0;
                  state_d = S_LOAD_B;
                end
              end
            end
          end
        end
        S_LOAD_B: begin
          if (beat) begin
            b_we_d    = 1'b1;
            b_addr_d  = {n_q, k_q};
            wr_data_d = in_data;
`ifdef PARAM_LOADER_CHECKSUM_EN
            sum_d     = sum_q + in_data;
`endif
            if (!last_k) begin
              k_d = k_q + 2'd1;
            end else begin
              k_d = 2'd0;
              if (!last_n) begin
                n_d = n_q + 3'd1;
              end else begin
                n_d = 3'd0;
`ifdef PARAM_LOADER_CHECKSUM_EN
                state_d = S_CHK;
`else
                state_d = S_DONE;
`endif
              end
            end
          end
        end
`ifdef PARAM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (beat) begin
            err_d   = (in_data != sum_q);
            state_d = S_DONE;
          end
        end
`endif
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    in_ready_d = (state_d == S_LOAD_W) || (state_d == S_LOAD_B);
`ifdef PARAM_LOADER_CHECKSUM_EN
    if (state_d == S_CHK) begin
      in_ready_d = 1'b1;
    end
`endif
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= 3'd0;
      i_q        <= 2'd0;
      k_q        <= 2'd0;
      in_ready_q <= 1'b0;
      w_we_q     <= 1'b0;
      b_we_q     <= 1'b0;
      w_addr_q   <= 7'd0;
      b_addr_q   <= 5'd0;
      wr_data_q  <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
      sum_q      <= 16'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      k_q        <= k_d;
      in_ready_q <= in_ready_d;
      w_we_q     <= w_we_d;
      b_we_q     <= b_we_d;
      w_addr_q   <= w_addr_d;
      b_addr_q   <= b_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PARAM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign w_we     = w_we_q;
  assign w_addr   = w_addr_q;
  assign b_we     = b_we_q;
  assign b_addr   = b_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef PARAM_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_param_loader.sv
// Scoreboard bench for param_loader: default instance plus a 5x3x2 instance.
module tb_param_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start, abort, in_valid;
  logic [15:0] in_data;
  logic        in_ready, w_we, b_we, busy, done, err;
  logic [6:0]  w_addr;
  logic [4:0]  b_addr;
  logic [15:0] wr_data;

  logic        s_start, s_abort, s_in_valid;
  logic [15:0] s_in_data;
  logic        s_in_ready, s_w_we, s_b_we, s_busy, s_done, s_err;
  logic [6:0]  s_w_addr;
  logic [4:0]  s_b_addr;
  logic [15:0] s_wr_data;

  param_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_we(w_we), .w_addr(w_addr), .b_we(b_we), .b_addr(b_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  param_loader #(.N_NEURONS(5), .N_INPUTS(3), .K_WORDS(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .w_we(s_w_we), .w_addr(s_w_addr), .b_we(s_b_we), .b_addr(s_b_addr),
    .wr_data(s_wr_data), .busy(s_busy), .done(s_done), .err(s_err)
  );

  // kind: 2'b01 weight write, 2'b10 bias write, 2'b00 done without write
  typedef struct packed {
    logic [1:0]  kind;
    logic [6:0]  addr;
    logic [15:0] data;
    logic        done;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t sq[$];
  int checks = 0;
  int passes = 0;
  int s_wcnt = 0, s_bcnt = 0;
  logic [6:0] s_wlast = '0;
  logic [4:0] s_blast = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int sel, input logic [1:0] kind, input int addr,
                      input logic [15:0] data, input logic dn, input logic er);
    exp_t e;
    e.kind = kind; e.addr = 7'(addr); e.data = data; e.done = dn; e.err = er;
    if (sel == 0) q.push_back(e); else sq.push_back(e);
  endtask

  task automatic compare(input string tag, input exp_t e, input logic ww, input logic bw,
                         input logic [6:0] wa, input logic [4:0] ba, input logic [15:0] wd,
                         input logic dn, input logic er);
    logic [6:0] a;
    a = bw ? {2'b00, ba} : wa;
    if (e.kind == 2'b00)
      check({tag, "_done_only"}, {bw, ww, dn, er}, {e.kind, e.done, e.err});
    else
      check({tag, "_write"}, {bw, ww, a, wd, dn, er}, {e.kind, e.addr, e.data, e.done, e.err});
  endtask

  always @(negedge clk) begin
    if (rst_n && (w_we || b_we || done)) begin
      if (q.size() == 0) check("unexpected_output", {b_we, w_we, done}, 0);
      else compare("main", q.pop_front(), w_we, b_we, w_addr, b_addr, wr_data, done, err);
    end
  end

  always @(negedge clk) begin
    if (rst_n && (s_w_we || s_b_we || s_done)) begin
      if (s_w_we) begin s_wcnt++; s_wlast = s_w_addr; end
      if (s_b_we) begin s_bcnt++; s_blast = s_b_addr; end
      if (sq.size() == 0) check("s_unexpected_output", {s_b_we, s_w_we, s_done}, 0);
      else compare("small", sq.pop_front(), s_w_we, s_b_we, s_w_addr, s_b_addr, s_wr_data, s_done, s_err);
    end
  end

  task automatic drive(input int sel, input logic v, input logic [15:0] d, input logic st, input logic ab);
    if (sel == 0) begin in_valid = v; in_data = d; start = st; abort = ab; end
    else begin s_in_valid = v; s_in_data = d; s_start = st; s_abort = ab; end
  endtask

  // Holds the word until it is accepted; returns #1 after the accepting edge.
  task automatic beat(input int sel, input logic [15:0] d, input logic st, input logic ab);
    int waited = 0;
    logic rdy;
    drive(sel, 1'b1, d, st, ab);
    @(negedge clk);
    rdy = (sel == 0) ? in_ready : s_in_ready;
    while (!rdy && waited < 50) begin
      @(negedge clk);
      rdy = (sel == 0) ? in_ready : s_in_ready;
      waited++;
    end
    if (!rdy) check("ready_timeout", rdy, 1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic do_start(input int sel);
    if (sel == 0) start = 1'b1; else s_start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_start = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check(name, {in_ready, w_we, b_we, busy, done, err, w_addr, b_addr, wr_data}, 0);
  endtask

  task automatic run_load(input int sel, input int mode, input logic [15:0] chk_off);
    int nn, ii, kk, idx;
    logic [15:0] d, sum;
    logic last, bsy;
    nn = (sel == 0) ? 8 : 5;
    ii = (sel == 0) ? 4 : 3;
    kk = (sel == 0) ? 4 : 2;
    idx = 0; sum = '0;
    do_start(sel);
    for (int n = 0; n < nn; n++)
      for (int i = 0; i < ii; i++)
        for (int k = 0; k < kk; k++) begin
          d = (mode == 1) ? 16'd1 : 16'(idx);
          sum = sum + d;
          push(sel, 2'b01, k + 4*i + 16*n, d, 1'b0, 1'b0);
          if (sel == 1 && $urandom_range(0, 9) < 3) begin @(posedge clk); #1; end
          beat(sel, d, (sel == 0 && idx == 50), 1'b0);
          idx++;
        end
    for (int n = 0; n < nn; n++)
      for (int k = 0; k < kk; k++) begin
        d = (mode == 1) ? 16'd1 : 16'(idx);
        sum = sum + d;
        last = (n == nn-1) && (k == kk-1);
`ifdef PARAM_LOADER_CHECKSUM_EN
        push(sel, 2'b10, k + 4*n, d, 1'b0, 1'b0);
`else
        push(sel, 2'b10, k + 4*n, d, last, 1'b0);
`endif
        if (sel == 1 && $urandom_range(0, 9) < 3) begin @(posedge clk); #1; end
        beat(sel, d, (sel == 0 && idx == 140), 1'b0);
        idx++;
      end
`ifdef PARAM_LOADER_CHECKSUM_EN
    push(sel, 2'b00, 0, 16'd0, 1'b1, (chk_off != 0));
    beat(sel, sum + chk_off, 1'b0, 1'b0);
`endif
    @(negedge clk);
    bsy = (sel == 0) ? busy : s_busy;
    check("busy_in_done_cycle", bsy, 1);
    @(negedge clk);
    bsy = (sel == 0) ? busy : s_busy;
    check("busy_dropped", bsy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'd0, 1'b0, 1'b0);
    #23;
    check_zero("reset_outputs");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of the weight phase after 37 beats
    do_start(0);
    for (int b = 0; b < 37; b++) begin
      push(0, 2'b01, b, 16'(b), 1'b0, 1'b0);
      beat(0, 16'(b), 1'b0, 1'b0);
    end
    @(posedge clk); #2;
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("reset_midload");
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full default stream, start pulses at beats 50 and 140 must be ignored
    run_load(0, 0, 16'd0);

    // Abort on the beat that would write bias address 5
    do_start(0);
    for (int b = 0; b < 133; b++) begin
      push(0, (b < 128) ? 2'b01 : 2'b10, (b < 128) ? b : b - 128, 16'(b), 1'b0, 1'b0);
      beat(0, 16'(b), 1'b0, 1'b0);
    end
    beat(0, 16'd133, 1'b0, 1'b1);
    @(negedge clk);
    check("abort_idle", {busy, in_ready}, 0);
    repeat (5) @(posedge clk);
    #1;

    // Small instance with random valid gaps
    run_load(1, 0, 16'd0);
    check("s_weight_count", s_wcnt, 30);
    check("s_bias_count", s_bcnt, 10);
    check("s_last_w_addr", s_wlast, 7'h49);
    check("s_last_b_addr", s_blast, 5'h11);

`ifdef PARAM_LOADER_CHECKSUM_EN
    run_load(0, 1, 16'd0);
    run_load(0, 1, 16'd1);
    @(negedge clk);
    check("err_held", err, 1);
    @(posedge clk); #1;
    do_start(0);
    @(negedge clk);
    check("err_cleared_on_start", err, 0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
`endif

    repeat (3) @(posedge clk);
    check("main_queue_drained", q.size(), 0);
    check("small_queue_drained", sq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
